// File: rtl/instreg_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instreg_queue
//  Purpose  : DEPTH-entry instruction queue between fetch and decode.
//             Strict FIFO with valid/ready handshakes on both sides, a
//             synchronous flush for branch redirects, and a registered head
//             output (data_out) with its opcode field sliced out for decode.
//  Ports    : clk       - system clock (rising edge)
//             reset     - synchronous active-high reset
//             flush     - synchronous discard of all queued instructions
//             in_valid  - fetch offers data_in
//             in_ready  - queue can accept (count < DEPTH)
//             data_in   - instruction from fetch
//             out_valid - data_out holds a valid head instruction
//             out_ready - decode consumes the head
//             data_out  - registered head instruction
//             opcode    - data_out[WIDTH-1 -: OPW]
//             count     - number of valid entries, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module instreg_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int OPW   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic [OPW-1:0]             opcode,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    // Storage is never reset; entries are only logically invalidated.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic push;
    logic pop;

    // Handshake flags depend on registered count only, so in_ready never
    // combinationally depends on out_ready.
    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointers wrap for free because DEPTH is a power of two.
    assign rd_ptr_nxt = rd_ptr_q + 1'b1;

    assign data_out = data_out_q;
    assign opcode   = data_out_q[WIDTH-1 -: OPW];
    assign count    = count_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (flush) begin
            // Same-cycle push/pop are dropped; the head value is kept visible.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_nxt;
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + C_ONE;
                2'b01:   count_d = count_q - C_ONE;
                default: count_d = count_q;
            endcase

            // Head register mirrors mem_q[rd_ptr]. When the next head is not
            // yet in storage (queue empty, or only the popped entry left) it
            // comes straight from data_in, still one cycle after the push.
            if (pop && (count_q > C_ONE)) begin
                data_out_d = mem_q[rd_ptr_nxt];
            end else if (push && ((count_q == '0) || pop)) begin
                data_out_d = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule
`default_nettype wire
